xor_share_arbiter: RTL and testbench
====================================

# xor_share_arbiter

Round-robin arbiter and sequencer that shares a single external 8-bit bitwise-XOR datapath (`Xor8Bits`) among `N_REQ` requesters. It latches the winning requester's operands, drives them to the XOR unit, captures the result one cycle later and returns it with a one-hot completion pulse. It sits between the requester blocks and the one XOR instance, so the XOR unit never sees conflicting operand sources.

## Interface
- `N_REQ`, default 4: number of requesters; legal range 2..8.
- `IDW`, default 2: width of the internal owner/pointer registers, equal to clog2(`N_REQ`) and at least 1.

- `clk`  in  1: single clock, rising-edge.
- `reset`  in  1: synchronous, active-high.
- `REQ`  in  `N_REQ`: per-requester operation request.
- `A_IN`  in  8*`N_REQ`: operand A; requester i uses bits [8i+7:8i].
- `B_IN`  in  8*`N_REQ`: operand B, same packing as `A_IN`.
- `LOCK`  in  `N_REQ`: per-requester lock request. Present only with `XOR_ARB_LOCK_EN`.
- `GNT`  out  `N_REQ`: one-hot grant pulse; operands have been latched.
- `DONE`  out  `N_REQ`: one-hot completion pulse.
- `R`  out  8: result register.
- `XA`  out  8: operand A to the XOR unit.
- `XB`  out  8: operand B to the XOR unit.
- `XS`  in  8: result from the XOR unit; combinational from `XA`/`XB`.

## Operation
- FSM states: IDLE → EXEC → DONE → IDLE. There is no other state.
- **IDLE**
  - If `REQ` is zero, stay in IDLE.
  - Otherwise pick winner w: the first set `REQ` bit searching from (`ptr`+1) mod `N_REQ` upward with wrap-around.
  - Latch `A_IN`[w] and `B_IN`[w] into the operand registers, and latch w into `owner`.
  - Set `GNT` to one-hot w, then go to EXEC.
- **EXEC**
  - `R` ← `XS`.
  - `GNT` ← 0.
  - `DONE` ← one-hot `owner`.
  - Go to DONE.
- **DONE**
  - `DONE` ← 0.
  - `ptr` ← `owner`.
  - Go to IDLE.
- `XA`/`XB` are driven continuously from the operand registers. They change only on a grant.
- `R` holds its value until the next EXEC capture.
- `REQ` is sampled only in IDLE. A requester must hold `REQ` and its operands until it sees `GNT`.
  - It must deassert `REQ` before the first IDLE sample following its `DONE` pulse; otherwise a new operation is issued with the current operands.
- Changes to `REQ`, `A_IN` and `B_IN` during EXEC/DONE are ignored.
- An unused requester with `REQ` tied low is never granted.
- Reset values:
  - state = IDLE.
  - `GNT` = 0, `DONE` = 0, `R` = 0, `XA` = 0, `XB` = 0.
  - `ptr` = `N_REQ`−1, so requester 0 wins first after reset.
  - `owner` = 0.
- Reset asserted mid-operation aborts it: no `DONE` is issued, `R` is cleared, and the aborted requester gets no priority credit.

## Timing
- Let `REQ[i]` be sampled at edge k in IDLE.
  - After edge k: `GNT[i]`=1.
  - After edge k+1: `GNT`=0, `DONE[i]`=1, and `R` is valid.
  - After edge k+2: `DONE`=0.
- Next arbitration is at edge k+3. Peak throughput is one operation per 3 cycles.
- Latency from request to result is 2 cycles; `R` is valid in the same cycle `DONE` is high.
- `XS` must settle within one cycle of an `XA`/`XB` change. This is guaranteed by the single-level XOR datapath.
- Fairness: with all requesters continuously requesting, each is granted exactly once every `N_REQ` operations (every 3·`N_REQ` cycles).

## Configuration
- `XOR_ARB_LOCK_EN` defined:
  - The `LOCK` port exists.
  - In IDLE, if `REQ[owner]` && `LOCK[owner]`, `owner` wins regardless of `ptr`.
  - `ptr` still updates normally, so rotation resumes from `owner` once the lock drops.
  - `LOCK` on a non-owner has no effect.
- Not defined:
  - No `LOCK` port.
  - Arbitration is pure round-robin.

## Test plan
- Reset, then `REQ`=0001, A0=0xF0, B0=0x3C → `GNT`=0001 one cycle after the sample, then `DONE`=0001 with `R`=0xCC. `XA`=0xF0 and `XB`=0x3C from the grant onward.
- `REQ`=1111 held continuously with distinct operands → grant order 0,1,2,3,0,…, each grant 3 cycles apart, and each `R` matches that requester's A^B.
- After requester 3 wins, `REQ`=1001 → requester 0 wins next (wrap-around), then requester 3.
- Assert `reset` during EXEC → next cycle `GNT`=`DONE`=`R`=0 and state IDLE; a subsequent `REQ`=0100 is granted immediately.
- Requester changes A_IN to 0xFF after `GNT` → `R` reflects the latched operands, not 0xFF. Requester holds `REQ` through DONE → a second operation is issued to it.
- With `XOR_ARB_LOCK_EN`: requester 1 holds `REQ`+`LOCK` while requester 2 requests → requester 1 is granted repeatedly. When `LOCK` drops, requester 2 wins next.

Source files
------------

// File: rtl/xor_share_arbiter.sv
// ----------------------------------------------------------------------------
// xor_share_arbiter
//
// Round-robin arbiter/sequencer that shares one external 8-bit XOR datapath
// among N_REQ requesters. The winner's operands are latched and driven to the
// XOR unit, the result is captured one cycle later, and completion is
// signalled with a one-hot DONE pulse. One operation every three cycles:
// IDLE (arbitrate + latch) -> EXEC (capture) -> DONE (commit priority).
//
// Parameters
//   N_REQ : number of requesters (2..8)
//   IDW   : owner/pointer register width, clog2(N_REQ), at least 1
//
// Ports
//   clk   in  1        rising-edge clock
//   reset in  1        synchronous, active-high
//   REQ   in  N_REQ    per-requester request
//   A_IN  in  8*N_REQ  operand A, requester i at [8i+7:8i]
//   B_IN  in  8*N_REQ  operand B, same packing
//   LOCK  in  N_REQ    per-requester lock (only with XOR_ARB_LOCK_EN)
//   GNT   out N_REQ    one-hot grant pulse (operands latched)
//   DONE  out N_REQ    one-hot completion pulse
//   R     out 8        result register
//   XA    out 8        operand A to the XOR unit
//   XB    out 8        operand B to the XOR unit
//   XS    in  8        XOR unit result (combinational from XA/XB)
//
// Build option
//   XOR_ARB_LOCK_EN : adds LOCK; a locked, requesting owner keeps winning.
// ----------------------------------------------------------------------------
module xor_share_arbiter #(
    parameter int N_REQ = 4,
    parameter int IDW   = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [N_REQ-1:0]   REQ,
    input  logic [8*N_REQ-1:0] A_IN,
    input  logic [8*N_REQ-1:0] B_IN,
`ifdef XOR_ARB_LOCK_EN
    input  logic [N_REQ-1:0]   LOCK,
`endif
    output logic [N_REQ-1:0]   GNT,
    output logic [N_REQ-1:0]   DONE,
    output logic [7:0]         R,
    output logic [7:0]         XA,
    output logic [7:0]         XB,
    input  logic [7:0]         XS
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXEC,
        S_DONE
    } state_e;

    state_e             state_q, state_d;
    logic [N_REQ-1:0]   gnt_q, gnt_d;
    logic [N_REQ-1:0]   done_q, done_d;
    logic [7:0]         r_q, r_d;
    logic [7:0]         xa_q, xa_d;
    logic [7:0]         xb_q, xb_d;
    logic [IDW-1:0]     owner_q, owner_d;
    logic [IDW-1:0]     ptr_q, ptr_d;

    logic [IDW-1:0]     win;
    logic [IDW-1:0]     cand;
    logic               found;
    int unsigned        cand_n;

    // State register plus all datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            gnt_q   <= '0;
            done_q  <= '0;
            r_q     <= '0;
            xa_q    <= '0;
            xb_q    <= '0;
            owner_q <= '0;
            ptr_q   <= IDW'(N_REQ - 1);
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            done_q  <= done_d;
            r_q     <= r_d;
            xa_q    <= xa_d;
            xb_q    <= xb_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (|REQ) state_d = S_EXEC;
            S_EXEC:  state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Winner search: first set REQ bit starting at ptr+1, wrapping modulo
    // N_REQ (non-power-of-two N_REQ makes a plain IDW-bit wrap unusable).
    always_comb begin
        win    = ptr_q;
        found  = 1'b0;
        cand   = '0;
        cand_n = 0;
        for (int unsigned i = 1; i <= N_REQ; i++) begin
            cand_n = 32'(ptr_q) + i;
            if (cand_n >= N_REQ) cand_n = cand_n - N_REQ;
            cand = IDW'(cand_n);
            if (!found && REQ[cand]) begin
                win   = cand;
                found = 1'b1;
            end
        end
`ifdef XOR_ARB_LOCK_EN
        // A locked owner that is still requesting overrides rotation.
        if (REQ[owner_q] && LOCK[owner_q]) begin
            win = owner_q;
        end
`endif
    end

    // Output / datapath next values.
    always_comb begin
        gnt_d   = '0;
        done_d  = '0;
        r_d     = r_q;
        xa_d    = xa_q;
        xb_d    = xb_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        case (state_q)
            S_IDLE: begin
                if (|REQ) begin
                    owner_d = win;
                    for (int unsigned i = 0; i < N_REQ; i++) begin
                        if (IDW'(i) == win) begin
                            xa_d     = A_IN[8*i +: 8];
                            xb_d     = B_IN[8*i +: 8];
                            gnt_d[i] = 1'b1;
                        end
                    end
                end
            end
            S_EXEC: begin
                r_d = XS;
                for (int unsigned i = 0; i < N_REQ; i++) begin
                    done_d[i] = (IDW'(i) == owner_q);
                end
            end
            S_DONE: begin
                // Priority credit is only committed once the operation completes.
                ptr_d = owner_q;
            end
            default: ;
        endcase
    end

    assign GNT  = gnt_q;
    assign DONE = done_q;
    assign R    = r_q;
    assign XA   = xa_q;
    assign XB   = xb_q;

endmodule

// File: tb/tb_xor_share_arbiter.sv
module tb_xor_share_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  REQ;
    logic [31:0] A_IN;
    logic [31:0] B_IN;
    logic [3:0]  LOCK;
    logic [3:0]  GNT;
    logic [3:0]  DONE;
    logic [7:0]  R;
    logic [7:0]  XA;
    logic [7:0]  XB;
    logic [7:0]  XS;

    int n_asserts = 0;
    int n_fail    = 0;

    // Single-level XOR unit shared by the arbiter.
    assign XS = XA ^ XB;

    xor_share_arbiter #(.N_REQ(4), .IDW(2)) dut (
        .clk   (clk),
        .reset (reset),
        .REQ   (REQ),
        .A_IN  (A_IN),
        .B_IN  (B_IN),
`ifdef XOR_ARB_LOCK_EN
        .LOCK  (LOCK),
`endif
        .GNT   (GNT),
        .DONE  (DONE),
        .R     (R),
        .XA    (XA),
        .XB    (XB),
        .XS    (XS)
    );

    always #5 clk = ~clk;

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One full operation starting with an IDLE sample on the next edge.
    task automatic do_op(input string tag, input logic [3:0] g,
                         input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] r);
        tick();
        chk({tag, "_gnt"},  32'(GNT),  32'(g));
        chk({tag, "_xa"},   32'(XA),   32'(a));
        chk({tag, "_xb"},   32'(XB),   32'(b));
        chk({tag, "_done0"}, 32'(DONE), 32'h0);
        tick();
        chk({tag, "_gnt0"}, 32'(GNT),  32'h0);
        chk({tag, "_done"}, 32'(DONE), 32'(g));
        chk({tag, "_r"},    32'(R),    32'(r));
        tick();
        chk({tag, "_doneclr"}, 32'(DONE), 32'h0);
        chk({tag, "_rhold"},   32'(R),    32'(r));
    endtask

    initial begin
        reset = 1'b1;
        REQ   = 4'b0000;
        LOCK  = 4'b0000;
        A_IN  = 32'h0;
        B_IN  = 32'h0;
        tick();
        tick();
        reset = 1'b0;

        // Reset state
        chk("rst_gnt",  32'(GNT),  32'h0);
        chk("rst_done", 32'(DONE), 32'h0);
        chk("rst_r",    32'(R),    32'h0);
        chk("rst_xa",   32'(XA),   32'h0);
        chk("rst_xb",   32'(XB),   32'h0);

        // No request: nothing happens
        tick();
        tick();
        chk("idle_gnt", 32'(GNT), 32'h0);

        // Single request from requester 0: F0 ^ 3C = CC
        REQ  = 4'b0001;
        A_IN = 32'h000000F0;
        B_IN = 32'h0000003C;
        tick();
        chk("t1_gnt", 32'(GNT), 32'h1);
        chk("t1_xa",  32'(XA),  32'hF0);
        chk("t1_xb",  32'(XB),  32'h3C);
        REQ = 4'b0000;
        tick();
        chk("t1_done", 32'(DONE), 32'h1);
        chk("t1_r",    32'(R),    32'hCC);
        chk("t1_gnt0", 32'(GNT),  32'h0);
        tick();
        chk("t1_doneclr", 32'(DONE), 32'h0);
        chk("t1_xahold",  32'(XA),   32'hF0);

        // Fresh reset, then all requesting: order 0,1,2,3,0
        reset = 1'b1;
        tick();
        reset = 1'b0;
        A_IN = 32'h78563412;
        B_IN = 32'hAAF00FFF;
        REQ  = 4'b1111;
        do_op("rr0", 4'b0001, 8'h12, 8'hFF, 8'hED);
        do_op("rr1", 4'b0010, 8'h34, 8'h0F, 8'h3B);
        do_op("rr2", 4'b0100, 8'h56, 8'hF0, 8'hA6);
        do_op("rr3", 4'b1000, 8'h78, 8'hAA, 8'hD2);
        do_op("rr4", 4'b0001, 8'h12, 8'hFF, 8'hED);

        // Wrap-around: 3 wins, then 0, then 3
        REQ = 4'b1000;
        do_op("wr3", 4'b1000, 8'h78, 8'hAA, 8'hD2);
        REQ = 4'b1001;
        do_op("wr0", 4'b0001, 8'h12, 8'hFF, 8'hED);
        do_op("wr3b", 4'b1000, 8'h78, 8'hAA, 8'hD2);

        // Reset during EXEC aborts the operation
        REQ = 4'b0010;
        tick();
        chk("ab_gnt", 32'(GNT), 32'h2);
        reset = 1'b1;
        REQ   = 4'b0000;
        tick();
        reset = 1'b0;
        chk("ab_gnt0", 32'(GNT),  32'h0);
        chk("ab_done", 32'(DONE), 32'h0);
        chk("ab_r",    32'(R),    32'h0);
        chk("ab_xa",   32'(XA),   32'h0);
        REQ = 4'b0100;
        do_op("ab_next", 4'b0100, 8'h56, 8'hF0, 8'hA6);
        REQ = 4'b0000;

        // Operand change after GNT is ignored; held REQ issues a second op
        REQ = 4'b0001;
        tick();
        chk("lt_gnt", 32'(GNT), 32'h1);
        A_IN = 32'h785634FF;
        tick();
        chk("lt_done", 32'(DONE), 32'h1);
        chk("lt_r",    32'(R),    32'hED);
        tick();
        chk("lt_doneclr", 32'(DONE), 32'h0);
        do_op("lt_again", 4'b0001, 8'hFF, 8'hFF, 8'h00);
        REQ  = 4'b0000;
        A_IN = 32'h78563412;

`ifdef XOR_ARB_LOCK_EN
        // Locked requester 1 keeps winning over requester 2
        REQ  = 4'b0110;
        LOCK = 4'b0010;
        do_op("lk1a", 4'b0010, 8'h34, 8'h0F, 8'h3B);
        do_op("lk1b", 4'b0010, 8'h34, 8'h0F, 8'h3B);
        do_op("lk1c", 4'b0010, 8'h34, 8'h0F, 8'h3B);
        LOCK = 4'b0000;
        do_op("lk2", 4'b0100, 8'h56, 8'hF0, 8'hA6);
        REQ = 4'b0000;
`endif

        tick();
        chk("end_gnt", 32'(GNT), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
